// File: rtl/mem_rmw_responder.sv
// mem_rmw_responder
// Memory-side responder for the multicycle CPU. It serves word/halfword/byte
// loads, with lane extraction and sign extension, from a word-only synchronous
// memory. Sub-word stores are done as read-modify-write, so the memory only
// ever sees full-word writes.
// Optional feature macro: MEM_RMW_UNSIGNED_EN adds req_unsigned, which makes
// sub-word loads zero-extend instead of sign-extend.
module mem_rmw_responder #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef MEM_RMW_UNSIGNED_EN
  input  logic        req_unsigned,
`endif
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 2;

  // Latencies outside the supported 1..3 window are clamped into it.
  localparam int unsigned LAT_C = (MEM_LAT < 1) ? 1 : ((MEM_LAT > 3) ? 3 : MEM_LAT);
  // The counter runs down to zero; the zero cycle is the capture edge.
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_C - 1);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    WR      = 2'b10,
    RESP    = 2'b11
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         off_q;
  logic [1:0]         size_q;
  logic               wr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               uns_q;

  // Misaligned word/halfword or the reserved size code.
  function automatic logic req_err(input logic [1:0] size, input logic [1:0] off);
    logic e;
    e = 1'b0;
    case (size)
      SZ_WORD: e = (off != 2'b00);
      SZ_HALF: e = off[0];
      SZ_BYTE: e = 1'b0;
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Replace the addressed lane(s) of the old word; all other bits pass through.
  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] word,
                                                   input logic [1:0]        size,
                                                   input logic [1:0]        off,
                                                   input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] m;
    m = word;
    case (size)
      SZ_BYTE: m[{off, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: m[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  // Little-endian lane extraction with sign or zero extension.
  function automatic logic [DATA_W-1:0] load_lane(input logic [DATA_W-1:0] word,
                                                  input logic [1:0]        size,
                                                  input logic [1:0]        off,
                                                  input logic              uns);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

`ifdef MEM_RMW_UNSIGNED_EN
  // Zero-extension select, latched with the rest of the request.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      uns_q <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      uns_q <= req_unsigned;
    end
  end
`else
  assign uns_q = 1'b0;
`endif

  // Request FSM with registered memory-side and CPU-side outputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      off_q     <= 2'b00;
      size_q    <= SZ_WORD;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            off_q     <= req_addr[1:0];
            size_q    <= req_size;
            wr_q      <= req_wr;
            wdata_q   <= req_wdata;
            mem_addr  <= {req_addr[31:2], 2'b00};
            if (req_err(req_size, req_addr[1:0])) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end else if (req_wr && req_size == SZ_WORD) begin
              mem_wdata <= req_wdata;
              mem_wr    <= 1'b1;
              state     <= WR;
            end else begin
              cnt   <= LAT_LAST;
              state <= RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (wr_q) begin
            mem_wdata <= merge_lane(mem_rdata, size_q, off_q, wdata_q);
            mem_wr    <= 1'b1;
            state     <= WR;
          end else begin
            rsp_rdata <= load_lane(mem_rdata, size_q, off_q, uns_q);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        WR: begin
          mem_wr    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end

        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          mem_wr    <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rmw_responder.sv
// Directed bench for mem_rmw_responder: one instance with MEM_LAT=1 (index 0)
// and one with MEM_LAT=3 (index 1), each backed by a small word memory.
module tb_mem_rmw_responder;

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_B = 2'b01;
  localparam logic [1:0] SZ_H = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_wr    [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
`ifdef MEM_RMW_UNSIGNED_EN
  logic        req_unsigned [2];
`endif
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [31:0] mem_addr  [2];
  logic        mem_wr    [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  int n_pass  = 0;
  int n_total = 0;

  int          o_rsp_cyc, o_wr_cnt, o_wr_cyc, o_ready_seen, o_wait, o_addr_bad;
  logic [31:0] o_wdata, o_rdata;
  logic        o_err;

  always #5 clk = ~clk;

  mem_rmw_responder #(.MEM_LAT(1)) dut_l1 (
    .Clk(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_wr(req_wr[0]), .req_size(req_size[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef MEM_RMW_UNSIGNED_EN
    .req_unsigned(req_unsigned[0]),
`endif
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_rmw_responder #(.MEM_LAT(3)) dut_l3 (
    .Clk(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_wr(req_wr[1]), .req_size(req_size[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef MEM_RMW_UNSIGNED_EN
    .req_unsigned(req_unsigned[1]),
`endif
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Memory models: latency 1 reads combinationally, latency 3 via two registers.
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic [31:0] p0, p1;

  always @(posedge clk) begin
    if (mem_wr[0]) mem0[mem_addr[0][7:2]] <= mem_wdata[0];
  end
  assign mem_rdata[0] = mem0[mem_addr[0][7:2]];

  always @(posedge clk) begin
    if (mem_wr[1]) mem1[mem_addr[1][7:2]] <= mem_wdata[1];
    p0 <= mem1[mem_addr[1][7:2]];
    p1 <= p0;
  end
  assign mem_rdata[1] = p1;

  // Issue one request from a negedge and observe it up to its response.
  task automatic run_op(input int d, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic uns, input logic hold);
    int c;
    o_rsp_cyc = -1; o_wr_cnt = 0; o_wr_cyc = -1; o_ready_seen = 0; o_wait = 0;
    o_addr_bad = 0; o_wdata = '0; o_rdata = '0; o_err = 1'b0;
    req_valid[d] = 1'b1; req_wr[d] = wr; req_size[d] = size;
    req_addr[d] = addr; req_wdata[d] = wdata;
`ifdef MEM_RMW_UNSIGNED_EN
    req_unsigned[d] = uns;
`endif
    while (req_ready[d] !== 1'b1 && o_wait < 20) begin
      @(negedge clk);
      o_wait++;
    end
    if (req_ready[d] !== 1'b1) begin
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
      if (hold) begin
        req_addr[d]  = addr ^ 32'h0000_0010;
        req_wdata[d] = ~wdata;
      end else begin
        req_valid[d] = 1'b0;
      end
      if (req_ready[d] === 1'b1) o_ready_seen++;
      if (mem_addr[d] !== {addr[31:2], 2'b00}) o_addr_bad++;
      if (mem_wr[d] === 1'b1) begin
        o_wr_cnt++; o_wr_cyc = c; o_wdata = mem_wdata[d];
      end
      if (rsp_valid[d] === 1'b1) begin
        o_rsp_cyc = c; o_err = rsp_err[d]; o_rdata = rsp_rdata[d];
        break;
      end
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_total++; if (req_ready[d] !== 1'b1) $display("FAIL reset_req_ready[%0d] got %b exp 1", d, req_ready[d]); else n_pass++;
      n_total++; if (rsp_valid[d] !== 1'b0) $display("FAIL reset_rsp_valid[%0d] got %b exp 0", d, rsp_valid[d]); else n_pass++;
      n_total++; if (rsp_err[d] !== 1'b0) $display("FAIL reset_rsp_err[%0d] got %b exp 0", d, rsp_err[d]); else n_pass++;
      n_total++; if (mem_wr[d] !== 1'b0) $display("FAIL reset_mem_wr[%0d] got %b exp 0", d, mem_wr[d]); else n_pass++;
      n_total++; if (mem_addr[d] !== 32'h0) $display("FAIL reset_mem_addr[%0d] got %h exp 0", d, mem_addr[d]); else n_pass++;
      n_total++; if (mem_wdata[d] !== 32'h0) $display("FAIL reset_mem_wdata[%0d] got %h exp 0", d, mem_wdata[d]); else n_pass++;
      n_total++; if (rsp_rdata[d] !== 32'h0) $display("FAIL reset_rsp_rdata[%0d] got %h exp 0", d, rsp_rdata[d]); else n_pass++;
    end
  endtask

  task automatic test_word_store_load();
    run_op(0, 1'b1, SZ_W, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0);
    n_total++; if (o_wr_cnt !== 1) $display("FAIL wst_wr_cnt got %0d exp 1", o_wr_cnt); else n_pass++;
    n_total++; if (o_wr_cyc !== 1) $display("FAIL wst_wr_cyc got %0d exp 1", o_wr_cyc); else n_pass++;
    n_total++; if (o_wdata !== 32'hDEADBEEF) $display("FAIL wst_wdata got %h exp deadbeef", o_wdata); else n_pass++;
    n_total++; if (o_rsp_cyc !== 2) $display("FAIL wst_rsp_cyc got %0d exp 2", o_rsp_cyc); else n_pass++;
    n_total++; if (o_err !== 1'b0) $display("FAIL wst_err got %b exp 0", o_err); else n_pass++;
    n_total++; if (o_ready_seen !== 0 || o_addr_bad !== 0) $display("FAIL wst_ready_addr got %0d/%0d exp 0/0", o_ready_seen, o_addr_bad); else n_pass++;
    run_op(0, 1'b0, SZ_W, 32'h40, 32'h0, 1'b0, 1'b0);
    n_total++; if (o_rsp_cyc !== 2) $display("FAIL wld_rsp_cyc got %0d exp 2", o_rsp_cyc); else n_pass++;
    n_total++; if (o_rdata !== 32'hDEADBEEF) $display("FAIL wld_rdata got %h exp deadbeef", o_rdata); else n_pass++;
    n_total++; if (o_wr_cnt !== 0) $display("FAIL wld_wr_cnt got %0d exp 0", o_wr_cnt); else n_pass++;
  endtask

  task automatic test_byte_rmw();
    run_op(0, 1'b1, SZ_W, 32'h40, 32'h11223344, 1'b0, 1'b0);
    run_op(0, 1'b1, SZ_B, 32'h42, 32'hFFFFFFAB, 1'b0, 1'b0);
    n_total++; if (o_wr_cnt !== 1) $display("FAIL rmwb_wr_cnt got %0d exp 1", o_wr_cnt); else n_pass++;
    n_total++; if (o_wr_cyc !== 2) $display("FAIL rmwb_wr_cyc got %0d exp 2", o_wr_cyc); else n_pass++;
    n_total++; if (o_wdata !== 32'h11AB3344) $display("FAIL rmwb_wdata got %h exp 11ab3344", o_wdata); else n_pass++;
    n_total++; if (o_rsp_cyc !== 3) $display("FAIL rmwb_rsp_cyc got %0d exp 3", o_rsp_cyc); else n_pass++;
    n_total++; if (o_rdata !== 32'hDEADBEEF) $display("FAIL rmwb_rdata_kept got %h exp deadbeef", o_rdata); else n_pass++;
    run_op(0, 1'b1, SZ_H, 32'h40, 32'hFFFF5566, 1'b0, 1'b0);
    n_total++; if (o_wdata !== 32'h11AB5566) $display("FAIL rmwh_wdata got %h exp 11ab5566", o_wdata); else n_pass++;
    run_op(0, 1'b0, SZ_W, 32'h40, 32'h0, 1'b0, 1'b0);
    n_total++; if (o_rdata !== 32'h11AB5566) $display("FAIL rmw_readback got %h exp 11ab5566", o_rdata); else n_pass++;
  endtask

  task automatic test_sign_ext();
    logic [1:0]  sz [6];
    logic [31:0] ad [6];
    logic [31:0] ex [6];
    sz = '{SZ_B, SZ_B, SZ_B, SZ_B, SZ_H, SZ_H};
    ad = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h42, 32'h40};
    ex = '{32'hFFFFFFFF, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFF80, 32'hFFFF8000, 32'hFFFFF0FF};
    run_op(0, 1'b1, SZ_W, 32'h40, 32'h8000F0FF, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_op(0, 1'b0, sz[i], ad[i], 32'h0, 1'b0, 1'b0);
      n_total++; if (o_rdata !== ex[i] || o_rsp_cyc !== 2 || o_err !== 1'b0)
        $display("FAIL sext[%0d] got %h cyc %0d err %b exp %h cyc 2 err 0", i, o_rdata, o_rsp_cyc, o_err, ex[i]);
      else n_pass++;
    end
`ifdef MEM_RMW_UNSIGNED_EN
    run_op(0, 1'b0, SZ_H, 32'h42, 32'h0, 1'b1, 1'b0);
    n_total++; if (o_rdata !== 32'h00008000) $display("FAIL zext_half got %h exp 00008000", o_rdata); else n_pass++;
    run_op(0, 1'b0, SZ_B, 32'h40, 32'h0, 1'b1, 1'b0);
    n_total++; if (o_rdata !== 32'h000000FF) $display("FAIL zext_byte got %h exp 000000ff", o_rdata); else n_pass++;
    run_op(0, 1'b0, SZ_W, 32'h40, 32'h0, 1'b1, 1'b0);
    n_total++; if (o_rdata !== 32'h8000F0FF) $display("FAIL zext_word got %h exp 8000f0ff", o_rdata); else n_pass++;
`endif
  endtask

  task automatic test_misalign();
    logic        wr [5];
    logic [1:0]  sz [5];
    logic [31:0] ad [5];
    wr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    sz = '{SZ_W, SZ_H, SZ_R, SZ_W, SZ_H};
    ad = '{32'h41, 32'h43, 32'h40, 32'h42, 32'h41};
    run_op(0, 1'b0, SZ_W, 32'h40, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run_op(0, wr[i], sz[i], ad[i], 32'h55555555, 1'b0, 1'b0);
      n_total++; if (o_err !== 1'b1 || o_rsp_cyc !== 1) $display("FAIL mis_err[%0d] got err %b cyc %0d exp err 1 cyc 1", i, o_err, o_rsp_cyc); else n_pass++;
      n_total++; if (o_wr_cnt !== 0) $display("FAIL mis_wr[%0d] got %0d exp 0", i, o_wr_cnt); else n_pass++;
      n_total++; if (o_rdata !== 32'h8000F0FF) $display("FAIL mis_rdata[%0d] got %h exp 8000f0ff", i, o_rdata); else n_pass++;
    end
    run_op(0, 1'b0, SZ_W, 32'h40, 32'h0, 1'b0, 1'b0);
    n_total++; if (o_rdata !== 32'h8000F0FF) $display("FAIL mis_mem_kept got %h exp 8000f0ff", o_rdata); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_op(0, 1'b1, SZ_W, 32'h44, 32'hCAFEF00D, 1'b0, 1'b0);
    run_op(0, 1'b0, SZ_W, 32'h44, 32'h0, 1'b0, 1'b0);
    n_total++; if (o_wait !== 1) $display("FAIL b2b_wait1 got %0d exp 1", o_wait); else n_pass++;
    n_total++; if (o_rdata !== 32'hCAFEF00D) $display("FAIL b2b_word got %h exp cafef00d", o_rdata); else n_pass++;
    run_op(0, 1'b0, SZ_B, 32'h47, 32'h0, 1'b0, 1'b0);
    n_total++; if (o_wait !== 1) $display("FAIL b2b_wait2 got %0d exp 1", o_wait); else n_pass++;
    n_total++; if (o_rdata !== 32'hFFFFFFCA) $display("FAIL b2b_byte got %h exp ffffffca", o_rdata); else n_pass++;
    run_op(0, 1'b0, SZ_H, 32'h44, 32'h0, 1'b0, 1'b0);
    n_total++; if (o_rdata !== 32'hFFFFF00D) $display("FAIL b2b_half got %h exp fffff00d", o_rdata); else n_pass++;
  endtask

  task automatic test_latency();
    run_op(1, 1'b1, SZ_W, 32'h80, 32'h11223344, 1'b0, 1'b0);
    n_total++; if (o_rsp_cyc !== 2) $display("FAIL lat_wst_cyc got %0d exp 2", o_rsp_cyc); else n_pass++;
    run_op(1, 1'b0, SZ_W, 32'h80, 32'h0, 1'b0, 1'b0);
    n_total++; if (o_rsp_cyc !== 4) $display("FAIL lat_ld_cyc got %0d exp 4", o_rsp_cyc); else n_pass++;
    n_total++; if (o_rdata !== 32'h11223344) $display("FAIL lat_ld_rdata got %h exp 11223344", o_rdata); else n_pass++;
    run_op(1, 1'b1, SZ_B, 32'h81, 32'h000000AB, 1'b0, 1'b1);
    n_total++; if (o_wr_cnt !== 1 || o_wr_cyc !== 4) $display("FAIL lat_rmw_wr got cnt %0d cyc %0d exp 1/4", o_wr_cnt, o_wr_cyc); else n_pass++;
    n_total++; if (o_rsp_cyc !== 5) $display("FAIL lat_rmw_rsp got %0d exp 5", o_rsp_cyc); else n_pass++;
    n_total++; if (o_wdata !== 32'h1122AB44) $display("FAIL lat_rmw_wdata got %h exp 1122ab44", o_wdata); else n_pass++;
    n_total++; if (o_ready_seen !== 0 || o_addr_bad !== 0) $display("FAIL lat_hold got ready %0d addrbad %0d exp 0/0", o_ready_seen, o_addr_bad); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) $display("FAIL lat_idle got ready %b rsp %b exp 1/0", req_ready[1], rsp_valid[1]); else n_pass++;
    run_op(1, 1'b0, SZ_W, 32'h80, 32'h0, 1'b0, 1'b0);
    n_total++; if (o_rdata !== 32'h1122AB44) $display("FAIL lat_readback got %h exp 1122ab44", o_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    run_op(1, 1'b1, SZ_W, 32'h84, 32'hA5A5A5A5, 1'b0, 1'b0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_size[1] = SZ_H;
    req_addr[1] = 32'h86; req_wdata[1] = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    n_total++; if (req_ready[1] !== 1'b0) $display("FAIL rmid_busy got %b exp 0", req_ready[1]); else n_pass++;
    rst[1] = 1'b1;
    #1;
    n_total++; if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || mem_wr[1] !== 1'b0)
      $display("FAIL rmid_ctrl got ready %b rsp %b wr %b exp 1/0/0", req_ready[1], rsp_valid[1], mem_wr[1]);
    else n_pass++;
    n_total++; if (mem_addr[1] !== 32'h0 || rsp_rdata[1] !== 32'h0)
      $display("FAIL rmid_data got addr %h rdata %h exp 0/0", mem_addr[1], rsp_rdata[1]);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0 || mem_wr[1] !== 1'b0 || req_ready[1] !== 1'b1) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL rmid_quiet got %0d bad cycles exp 0", bad); else n_pass++;
    run_op(1, 1'b0, SZ_W, 32'h84, 32'h0, 1'b0, 1'b0);
    n_total++; if (o_rdata !== 32'hA5A5A5A5) $display("FAIL rmid_mem got %h exp a5a5a5a5", o_rdata); else n_pass++;
  endtask

  task automatic test_wr_abort();
    int bad;
    run_op(0, 1'b1, SZ_W, 32'h48, 32'h13572468, 1'b0, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_size[0] = SZ_W;
    req_addr[0] = 32'h48; req_wdata[0] = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n_total++; if (mem_wr[0] !== 1'b1) $display("FAIL wab_wr_on got %b exp 1", mem_wr[0]); else n_pass++;
    rst[0] = 1'b1;
    #1;
    n_total++; if (mem_wr[0] !== 1'b0 || mem_wdata[0] !== 32'h0) $display("FAIL wab_drop got wr %b wdata %h exp 0/0", mem_wr[0], mem_wdata[0]); else n_pass++;
    @(negedge clk);
    rst[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0 || mem_wr[0] !== 1'b0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL wab_quiet got %0d bad cycles exp 0", bad); else n_pass++;
    run_op(0, 1'b0, SZ_W, 32'h48, 32'h0, 1'b0, 1'b0);
    n_total++; if (o_rdata !== 32'h13572468) $display("FAIL wab_mem got %h exp 13572468", o_rdata); else n_pass++;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_size[d] = SZ_W;
      req_addr[d] = '0; req_wdata[d] = '0;
`ifdef MEM_RMW_UNSIGNED_EN
      req_unsigned[d] = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_sign_ext();
    test_misalign();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    test_wr_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_rmw_responder.md
Name: mem_rmw_responder

Overview:
- Memory-side responder for the multicycle CPU's load/store requests.
- Sits between the CPU datapath (initiator: address, write enable, data-size select) and the word-only synchronous memory.
- Serves word, halfword and byte reads, extracting and sign-extending lanes.
- Serves sub-word writes by read-modify-write, so the memory itself only ever sees full-word writes.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from address to valid mem_rdata; legal range 1..3.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_wr  input  1  1 = store, 0 = load.
- req_size  input  2  00 word, 01 byte, 10 halfword, 11 reserved.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; sub-word data in the LSBs.
- req_ready  output  1  responder idle; request accepted when req_valid && req_ready at a rising edge.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  load result; held until the next rsp_valid.
- rsp_err  output  1  misaligned/reserved request; qualified by rsp_valid.
- mem_addr  output  32  word address to memory, {req_addr[31:2],2'b00}.
- mem_wr  output  1  memory write strobe.
- mem_wdata  output  32  full word to memory.
- mem_rdata  input  32  memory read data.

Behaviour:
- Reset (async, immediate): state IDLE, req_ready=1, mem_wr=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
- States: IDLE, RD_WAIT, WR, RESP.
- Request capture:
  - On acceptance, addr, size, wr and wdata are latched.
  - Inputs are ignored while req_ready=0.
  - req_ready=1 only in IDLE.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0; a halfword at addr[1]=0 occupies bits 15:0.
- Error check at acceptance; an error request goes IDLE->RESP, asserts rsp_err=1, leaves rsp_rdata unchanged and never asserts mem_wr. Errors are:
  - word with addr[1:0]!=0;
  - halfword with addr[0]=1;
  - size 11.
- Word store:
  - IDLE->WR->RESP.
  - WR drives mem_wr=1 for exactly one cycle, mem_wdata=latched wdata.
  - rsp_valid on the 2nd cycle after acceptance.
- Load:
  - IDLE->RD_WAIT (MEM_LAT cycles, counter)->RESP.
  - mem_rdata is captured on the last RD_WAIT edge.
  - rsp_rdata is the word, {24{b[7]},b} or {16{h[15]},h}, according to size.
  - rsp_valid at cycle MEM_LAT+1.
- Sub-word store (RMW):
  - IDLE->RD_WAIT->WR->RESP.
  - The captured word is merged with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]; other lanes are preserved bit-exact.
  - WR writes the merged word; rsp_valid at cycle MEM_LAT+2.
  - rsp_rdata is not updated on stores.
- mem_addr is held stable from acceptance through WR; mem_wr is 0 in all states except WR.
- RESP lasts one cycle, then returns to IDLE. No back-pressure on the response; the CPU FSM must sample the pulse.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately following RESP.
- Reset mid-operation: abort to IDLE. A pending RMW never writes. A WR cycle in progress drops mem_wr asynchronously; no response is issued.

Optional Feature:
- MEM_RMW_UNSIGNED_EN
- Defined: adds input req_unsigned (1 bit, latched at acceptance). When 1, byte/halfword loads zero-extend ({24'b0,b}, {16'b0,h}); word loads and stores are unaffected.
- Undefined: port absent; sub-word loads always sign-extend.

Test Plan:
- Word store then load, MEM_LAT=1:
  - store 0xDEADBEEF to 0x40 -> single mem_wr pulse, mem_wdata=0xDEADBEEF, rsp_valid 2 cycles after accept.
  - load word 0x40 -> rsp_rdata=0xDEADBEEF at cycle 2.
- Byte RMW: memory[0x40]=0x11223344, store byte 0xAB at 0x42 -> exactly one mem_wr, mem_wdata=0x11AB3344, rsp_valid at cycle 3.
- Sign-extending loads on word 0x8000F0FF:
  - byte at 0x40 -> 0xFFFFFFFF;
  - byte at 0x41 -> 0xFFFFFFF0;
  - halfword at 0x42 -> 0xFFFF8000;
  - with MEM_RMW_UNSIGNED_EN and req_unsigned=1, halfword at 0x42 -> 0x00008000.
- Misalignment: word at 0x41, halfword at 0x43, size 11 -> each gives rsp_err=1 one cycle after accept, mem_wr never asserted, rsp_rdata unchanged.
- Latency sweep with MEM_LAT=3: load -> rsp_valid at cycle 4; byte store -> mem_wr at cycle 4, rsp_valid at cycle 5; req_valid held high during the op is not re-accepted until req_ready returns.
- Reset asserted during RD_WAIT of a halfword store -> outputs reset immediately, memory contents unchanged, no rsp_valid, req_ready=1 after release.
